rmii_frame_tx: RTL and testbench

Streaming RMII Ethernet transmitter. It takes a payload as a byte stream with valid/ready/last framing and emits a complete Ethernet II frame on the 2-bit RMII TX pins: preamble, SFD, MAC header, payload, zero pad to minimum size, computed FCS, then inter-packet gap. It replaces the fixed-length, fixed-FCS transmitter in the Ethernet logic-analyzer path. Frame length is now variable and the FCS is computed in-line.

---
 rtl/eth_pkg.sv | 35 +++
 rtl/crc32_dibit.sv | 27 ++
 rtl/rmii_frame_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_rmii_frame_tx.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: framing constants, CRC-32 parameters,
// transmitter state encoding and the per-dibit reflected CRC step.
package eth_pkg;

   localparam logic [63:0] PREAMBLE_SFD    = 64'h55_55_55_55_55_55_55_D5;
   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
   localparam int          MIN_PAYLOAD     = 46;

   localparam int PREAMBLE_DIBITS = 32;
   localparam int HEADER_DIBITS   = 56;
   localparam int FCS_DIBITS      = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_HEADER,
      ST_PAYLOAD,
      ST_PAD,
      ST_FCS,
      ST_IPG,
      ST_DRAIN
   } tx_state_t;

   // Two serial steps of the reflected CRC; d[0] goes on the wire first.
   function automatic logic [31:0] crc32_step2(input logic [31:0] crc, input logic [1:0] d);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 2; i++) begin
         c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Running CRC-32 (reflected 0xEDB88320) advanced by one RMII dibit per enabled cycle.
module crc32_dibit
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        en,
   input  logic [1:0]  d,
   output logic [31:0] crc
);

   logic [31:0] crc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_reg <= CRC32_INIT;
      end else if (clear) begin
         crc_reg <= CRC32_INIT;
      end else if (en) begin
         crc_reg <= crc32_step2(crc_reg, d);
      end
   end

   assign crc = crc_reg;

endmodule

// File: rtl/rmii_frame_tx.sv
// Streaming RMII Ethernet II transmitter: preamble, header, payload, pad, in-line FCS, IPG.
// Each cycle the FSM picks the dibit registered onto TXD, so IDLE already emits the first preamble dibit.
module rmii_frame_tx
   import eth_pkg::*;
#(
   parameter logic [47:0] SRC_MAC     = 48'h69_69_69_69_69_69,
   parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
   parameter logic [15:0] ETHERTYPE   = 16'h1234,
   parameter int          MAX_PAYLOAD = 1500,
   parameter int          IPG_DIBITS  = 48
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_tdata,
   input  logic       s_tvalid,
   input  logic       s_tlast,
   output logic       s_tready,
   output logic       txen,
   output logic [1:0] txd,
   output logic       busy,
   output logic       frame_done,
   output logic       err_underrun,
   output logic       err_oversize
);

   localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

   tx_state_t   state_reg, state_next;
   logic [15:0] cnt_reg, cnt_next;
   logic [10:0] byte_cnt_reg, byte_cnt_next;
   logic [7:0]  shift_reg, shift_next;
   logic        last_reg, last_next;
   logic        underrun_reg, underrun_next;
   logic        drain_reg, drain_next;
   logic        txen_reg, txen_next;
   logic [1:0]  txd_reg, dibit;
   logic        busy_reg, busy_next;
   logic        done_reg, done_next;
   logic        ur_reg, ur_next;
   logic        ov_reg, ov_next;
   logic        ready, crc_en, crc_clear;
   logic [7:0]  pre_byte, hdr_byte, in_byte;
   logic [31:0] crc_val, fcs_word;

   crc32_dibit u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (crc_clear),
      .en    (crc_en),
      .d     (dibit),
      .crc   (crc_val)
   );

   assign pre_byte = PREAMBLE_SFD[{3'd7 - cnt_reg[4:2], 3'b000} +: 8];
   assign hdr_byte = HDR[{4'd13 - cnt_reg[5:2], 3'b000} +: 8];
   // An underrun frame carries the uninverted CRC so every receiver rejects it.
   assign fcs_word = underrun_reg ? crc_val : ~crc_val;

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg + 16'd1;
      byte_cnt_next = byte_cnt_reg;
      shift_next    = shift_reg;
      last_next     = last_reg;
      underrun_next = underrun_reg;
      drain_next    = drain_reg;
      txen_next     = 1'b0;
      dibit         = 2'b00;
      done_next     = 1'b0;
      ur_next       = 1'b0;
      ov_next       = 1'b0;
      ready         = 1'b0;
      crc_en        = 1'b0;
      crc_clear     = 1'b0;
      in_byte       = 8'h00;
      case (state_reg)
         ST_IDLE: begin
            cnt_next      = 16'd0;
            byte_cnt_next = 11'd0;
            last_next     = 1'b0;
            underrun_next = 1'b0;
            drain_next    = 1'b0;
            crc_clear     = 1'b1;
            if (s_tvalid) begin
               state_next = ST_PREAMBLE;
               cnt_next   = 16'd1;
               txen_next  = 1'b1;
               dibit      = pre_byte[{cnt_reg[1:0], 1'b0} +: 2];
            end
         end
         ST_PREAMBLE: begin
            txen_next = 1'b1;
            dibit     = pre_byte[{cnt_reg[1:0], 1'b0} +: 2];
            if (cnt_reg == 16'(PREAMBLE_DIBITS - 1)) begin
               state_next = ST_HEADER;
               cnt_next   = 16'd0;
            end
         end
         ST_HEADER: begin
            txen_next = 1'b1;
            crc_en    = 1'b1;
            dibit     = hdr_byte[{cnt_reg[1:0], 1'b0} +: 2];
            if (cnt_reg == 16'(HEADER_DIBITS - 1)) begin
               state_next = ST_PAYLOAD;
               cnt_next   = 16'd0;
            end
         end
         ST_PAYLOAD: begin
            txen_next = 1'b1;
            crc_en    = 1'b1;
            if (cnt_reg[1:0] == 2'd0) begin
               // Byte slot: take the input byte, or substitute zero and end the frame on underrun.
               if (s_tvalid) begin
                  ready   = 1'b1;
                  in_byte = s_tdata;
                  if ((byte_cnt_reg + 11'd1 == 11'(MAX_PAYLOAD)) && !s_tlast) begin
                     ov_next    = 1'b1;
                     drain_next = 1'b1;
                     last_next  = 1'b1;
                  end else begin
                     last_next = s_tlast;
                  end
               end else begin
                  ur_next       = 1'b1;
                  underrun_next = 1'b1;
                  drain_next    = 1'b1;
                  last_next     = 1'b1;
               end
               shift_next    = in_byte;
               byte_cnt_next = byte_cnt_reg + 11'd1;
               dibit         = in_byte[1:0];
            end else begin
               dibit = shift_reg[{cnt_reg[1:0], 1'b0} +: 2];
            end
            if (cnt_reg[1:0] == 2'd3) begin
               cnt_next = 16'd0;
               if (last_reg) begin
                  state_next = (byte_cnt_reg < 11'(MIN_PAYLOAD)) ? ST_PAD : ST_FCS;
               end
            end
         end
         ST_PAD: begin
            txen_next = 1'b1;
            crc_en    = 1'b1;
            if (cnt_reg[1:0] == 2'd3) begin
               cnt_next      = 16'd0;
               byte_cnt_next = byte_cnt_reg + 11'd1;
               if (byte_cnt_reg + 11'd1 >= 11'(MIN_PAYLOAD)) begin
                  state_next = ST_FCS;
               end
            end
         end
         ST_FCS: begin
            txen_next = 1'b1;
            dibit     = fcs_word[{cnt_reg[3:0], 1'b0} +: 2];
            if (cnt_reg == 16'(FCS_DIBITS - 1)) begin
               done_next  = 1'b1;
               state_next = ST_IPG;
               cnt_next   = 16'd0;
            end
         end
         ST_IPG: begin
            if (cnt_reg == 16'(IPG_DIBITS - 1)) begin
               state_next = drain_reg ? ST_DRAIN : ST_IDLE;
               cnt_next   = 16'd0;
            end
         end
         ST_DRAIN: begin
            cnt_next = 16'd0;
            ready    = s_tvalid;
            if (s_tvalid && s_tlast) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      busy_next = (state_next != ST_IDLE) && (state_next != ST_DRAIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= 16'd0;
         byte_cnt_reg <= 11'd0;
         shift_reg    <= 8'h00;
         last_reg     <= 1'b0;
         underrun_reg <= 1'b0;
         drain_reg    <= 1'b0;
         txen_reg     <= 1'b0;
         txd_reg      <= 2'b00;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         ur_reg       <= 1'b0;
         ov_reg       <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         byte_cnt_reg <= byte_cnt_next;
         shift_reg    <= shift_next;
         last_reg     <= last_next;
         underrun_reg <= underrun_next;
         drain_reg    <= drain_next;
         txen_reg     <= txen_next;
         txd_reg      <= dibit;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         ur_reg       <= ur_next;
         ov_reg       <= ov_next;
      end
   end

   assign s_tready     = ready;
   assign txen         = txen_reg;
   assign txd          = txd_reg;
   assign busy         = busy_reg;
   assign frame_done   = done_reg;
   assign err_underrun = ur_reg;
   assign err_oversize = ov_reg;

endmodule

// File: tb/tb_rmii_frame_tx.sv
// Scoreboard bench for rmii_frame_tx: stimulus pushes expected wire frames, a monitor
// reassembles each TX_EN burst and compares bytes, length, pulses and inter-frame gap.
module tb_rmii_frame_tx;

   localparam int TMO = 3000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] s_tdata = 8'h00;
   logic       s_tvalid = 1'b0;
   logic       s_tlast = 1'b0;
   logic       s_tready, txen, busy, frame_done, err_underrun, err_oversize;
   logic [1:0] txd;

   logic        c_clear = 1'b0;
   logic        c_en = 1'b0;
   logic [1:0]  c_d = 2'b00;
   logic [31:0] c_crc;

   int checks = 0;
   int failures = 0;
   int frames = 0;

   typedef struct {
      int len;
      int ur;
      int ov;
      int gap;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] exp_bytes[$];
   logic [7:0] pl[0:127];
   logic [1:0] dib[$];
   int nd, nu, no, gap, cur_gap, in_frame;

   always #10 clk = ~clk;

   rmii_frame_tx #(.MAX_PAYLOAD(100)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tlast      (s_tlast),
      .s_tready     (s_tready),
      .txen         (txen),
      .txd          (txd),
      .busy         (busy),
      .frame_done   (frame_done),
      .err_underrun (err_underrun),
      .err_oversize (err_oversize)
   );

   crc32_dibit u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (c_clear),
      .en    (c_en),
      .d     (c_d),
      .crc   (c_crc)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int k = 0; k < 8; k++) begin
         r = (r[0] ^ b[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   // Expected wire image: preamble+SFD, header, payload (zero-filled to total), FCS.
   task automatic push_frame(input int n_real, input int total, input bit inv,
                             input int ur, input int ov, input int gp);
      logic [63:0]  pre;
      logic [111:0] hdr;
      logic [31:0]  c;
      logic [7:0]   b;
      exp_t         e;
      pre = 64'h55555555555555D5;
      hdr = {48'hFFFFFFFFFFFF, 48'h696969696969, 16'h1234};
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 8; i++) exp_bytes.push_back(pre[63-8*i -: 8]);
      for (int i = 0; i < 14; i++) begin
         b = hdr[111-8*i -: 8];
         exp_bytes.push_back(b);
         c = crc_byte(c, b);
      end
      for (int i = 0; i < total; i++) begin
         b = (i < n_real) ? pl[i] : 8'h00;
         exp_bytes.push_back(b);
         c = crc_byte(c, b);
      end
      if (!inv) c = ~c;
      for (int k = 0; k < 4; k++) exp_bytes.push_back(c[8*k +: 8]);
      e.len = 8 + 14 + total + 4;
      e.ur  = ur;
      e.ov  = ov;
      e.gap = gp;
      exp_q.push_back(e);
   endtask

   task automatic send(input int first, input int last_excl, input int stop_after, output int acc);
      int t;
      acc = 0;
      for (int i = first; i < last_excl; i++) begin
         if (stop_after > 0 && acc == stop_after) break;
         s_tdata  = pl[i];
         s_tvalid = 1'b1;
         s_tlast  = (i == last_excl - 1);
         t = 0;
         @(negedge clk);
         while (!s_tready && t < TMO) begin
            @(negedge clk);
            t++;
         end
         if (!s_tready) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: byte %0d not accepted within %0d cycles", i, TMO);
            break;
         end
         @(posedge clk);
         #1;
         acc++;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic check_frame();
      exp_t       e;
      int         mism, first;
      logic [7:0] a, x, fa, fx;
      frames++;
      $display("frame %0d: dibits=%0d gap=%0d done=%0d underrun=%0d oversize=%0d",
               frames, dib.size(), cur_gap, nd, nu, no);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_frame: got %0d dibits, required no frame", dib.size());
         return;
      end
      e = exp_q.pop_front();
      chk("frame_dibits", dib.size(), e.len * 4);
      mism = 0;
      first = -1;
      fa = 8'h00;
      fx = 8'h00;
      for (int i = 0; i < e.len; i++) begin
         x = exp_bytes.pop_front();
         a = 8'h00;
         if (4*i + 3 < dib.size()) a = {dib[4*i+3], dib[4*i+2], dib[4*i+1], dib[4*i]};
         if (4*i + 3 >= dib.size() || a !== x) begin
            if (first < 0) begin
               first = i;
               fa = a;
               fx = x;
            end
            mism++;
         end
      end
      checks++;
      if (mism != 0) begin
         failures++;
         $display("FAIL frame_bytes: %0d bad bytes, first at %0d got 0x%02h required 0x%02h",
                  mism, first, fa, fx);
      end
      chk("frame_done_count", nd, 1);
      chk("underrun_count", nu, e.ur);
      chk("oversize_count", no, e.ov);
      if (e.gap >= 0) chk("ipg_gap", cur_gap, e.gap);
   endtask

   // Monitor: samples on the falling edge, discards any burst cut short by reset.
   initial begin
      in_frame = 0;
      gap = 0;
      nd = 0; nu = 0; no = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            dib.delete();
            in_frame = 0;
            nd = 0; nu = 0; no = 0;
            continue;
         end
         if (txen) begin
            if (in_frame == 0) begin
               in_frame = 1;
               cur_gap = gap;
            end
            dib.push_back(txd);
            nd += int'(frame_done);
            nu += int'(err_underrun);
            no += int'(err_oversize);
         end else begin
            if (in_frame != 0) begin
               check_frame();
               dib.delete();
               in_frame = 0;
               gap = 0;
               nd = 0; nu = 0; no = 0;
            end
            gap++;
         end
      end
   end

   initial begin
      #10_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int    acc, t;
      string s;
      logic [7:0] b;

      s_tvalid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_txen", txen, 0);
      chk("reset_txd", txd, 0);
      chk("reset_tready", s_tready, 0);
      chk("reset_busy", busy, 0);
      chk("reset_pulses", {frame_done, err_underrun, err_oversize}, 0);
      s_tvalid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Stand-alone CRC: "123456789" LSB dibit first
      c_clear = 1'b1;
      @(negedge clk);
      c_clear = 1'b0;
      s = "123456789";
      for (int i = 0; i < 9; i++) begin
         b = s[i];
         for (int k = 0; k < 4; k++) begin
            c_en = 1'b1;
            c_d  = b[2*k +: 2];
            @(negedge clk);
         end
      end
      c_en = 1'b0;
      chk("crc_check_value", ~c_crc, 32'hCBF43926);

      // 2-byte frame, padded to 46
      pl[0] = 8'h12; pl[1] = 8'h34;
      push_frame(2, 46, 0, 0, 0, -1);
      send(0, 2, 0, acc);
      chk("f1_accepted", acc, 2);

      // 100-byte frame (exactly MAX_PAYLOAD with last), then one held off by the IPG
      for (int i = 0; i < 100; i++) pl[i] = 8'(i * 37 + 5);
      push_frame(100, 100, 0, 0, 0, -1);
      send(0, 100, 0, acc);
      chk("f2_accepted", acc, 100);
      pl[0] = 8'hAB; pl[1] = 8'hCD;
      push_frame(2, 46, 0, 0, 0, 48);
      send(0, 2, 0, acc);
      chk("f3_accepted", acc, 2);

      // Underrun at byte 10 of 60
      for (int i = 0; i < 60; i++) pl[i] = 8'hA0 + 8'(i);
      push_frame(9, 46, 1, 1, 0, -1);
      send(0, 60, 9, acc);
      chk("f4_first_part", acc, 9);
      repeat (20) @(posedge clk);
      #1;
      send(9, 60, 0, acc);
      chk("f4_drained", acc, 51);

      // Oversize: 116 offered, 100 sent, 16 drained
      for (int i = 0; i < 116; i++) pl[i] = 8'h3C ^ 8'(i);
      push_frame(100, 100, 0, 0, 1, -1);
      send(0, 116, 0, acc);
      chk("f5_all_consumed", acc, 116);

      pl[0] = 8'h5A; pl[1] = 8'hA5;
      push_frame(2, 46, 0, 0, 0, -1);
      send(0, 2, 0, acc);
      chk("f6_accepted", acc, 2);

      // Reset in the middle of a payload
      for (int i = 0; i < 60; i++) pl[i] = 8'(i);
      send(0, 60, 5, acc);
      chk("txen_before_reset", txen, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("txen_async_drop", txen, 0);
      chk("busy_async_drop", busy, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      pl[0] = 8'h12; pl[1] = 8'h34;
      push_frame(2, 46, 0, 0, 0, -1);
      send(0, 2, 0, acc);
      chk("f7_accepted", acc, 2);

      t = 0;
      while (exp_q.size() > 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("scoreboard_empty", exp_q.size(), 0);
      repeat (60) @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_txen", txen, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
